// File: rtl/systolic_result_drain.sv
// Result drain for the systolic array: snapshots the finished accumulators and streams
// the active N x N elements row-major over valid/ready. Optional macro: DRAIN_SATURATE_EN.
module systolic_result_drain #(
  parameter int SIZE       = 4,
  parameter int REG_C_BITS = 21,
  parameter int OUT_BITS   = 16
) (
  input  logic                              i_clock,
  input  logic                              i_reset,
  input  logic [SIZE*SIZE*REG_C_BITS-1:0]   i_c_full,
  input  logic [SIZE*SIZE-1:0]              i_finish,
  input  logic [2:0]                        XYZ,
  output logic [OUT_BITS-1:0]               o_data,
  output logic [2:0]                        o_row,
  output logic [2:0]                        o_col,
  output logic                              o_valid,
  input  logic                              i_ready,
  output logic                              o_last,
  output logic                              o_busy,
  output logic                              o_overrun
);

  localparam int         NUM_PE = SIZE * SIZE;
  localparam logic [2:0] SIZE_N = 3'(SIZE);

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    WAIT_CLR
  } state_t;

  state_t                          state;
  logic [NUM_PE*REG_C_BITS-1:0]    buffer;
  logic [2:0]                      n_q;
  logic [2:0]                      row;
  logic [2:0]                      col;
  logic [2:0]                      next_row;
  logic [2:0]                      next_col;
  logic [2:0]                      n_live;
  logic                            all_done;
  logic                            all_done_q;
  logic [REG_C_BITS-1:0]           sel_elem;

  always_comb begin
    if (XYZ == 3'd0 || XYZ > SIZE_N) begin
      n_live = SIZE_N;
    end else begin
      n_live = XYZ;
    end
  end

  // Only PEs inside the live N x N window gate completion.
  always_comb begin
    all_done = 1'b1;
    for (int r = 0; r < SIZE; r++) begin
      for (int c = 0; c < SIZE; c++) begin
        if (r < int'(n_live) && c < int'(n_live)) begin
          all_done = all_done & i_finish[r*SIZE+c];
        end
      end
    end
  end

  always_comb begin
    sel_elem = '0;
    for (int i = 0; i < NUM_PE; i++) begin
      if (i == int'(row) * SIZE + int'(col)) begin
        sel_elem = buffer[i*REG_C_BITS +: REG_C_BITS];
      end
    end
  end

  always_comb begin
    if (col == n_q - 3'd1) begin
      next_col = 3'd0;
      next_row = row + 3'd1;
    end else begin
      next_col = col + 3'd1;
      next_row = row;
    end
  end

`ifdef DRAIN_SATURATE_EN
  // Bits above the output sign must all match it, otherwise clamp toward the sign.
  logic [REG_C_BITS-OUT_BITS:0] sat_hi;
  assign sat_hi = sel_elem[REG_C_BITS-1:OUT_BITS-1];

  always_comb begin
    if ((&sat_hi) || !(|sat_hi)) begin
      o_data = sel_elem[OUT_BITS-1:0];
    end else if (sel_elem[REG_C_BITS-1]) begin
      o_data = {1'b1, {(OUT_BITS-1){1'b0}}};
    end else begin
      o_data = {1'b0, {(OUT_BITS-1){1'b1}}};
    end
  end
`else
  assign o_data = sel_elem[OUT_BITS-1:0];

  generate
    if (REG_C_BITS > OUT_BITS) begin : g_trunc
      logic unused_hi_bits;
      assign unused_hi_bits = ^sel_elem[REG_C_BITS-1:OUT_BITS];
    end
  endgenerate
`endif

  assign o_row  = row;
  assign o_col  = col;
  assign o_busy = (state != IDLE);

  // The array is released at capture; later completions while busy only flag overrun.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state      <= IDLE;
      buffer     <= '0;
      n_q        <= '0;
      row        <= '0;
      col        <= '0;
      o_valid    <= 1'b0;
      o_last     <= 1'b0;
      o_overrun  <= 1'b0;
      all_done_q <= 1'b0;
    end else begin
      all_done_q <= all_done;
      if (state != IDLE && all_done && !all_done_q) begin
        o_overrun <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (all_done) begin
            buffer  <= i_c_full;
            n_q     <= n_live;
            row     <= '0;
            col     <= '0;
            o_valid <= 1'b1;
            o_last  <= (n_live == 3'd1);
            state   <= DRAIN;
          end
        end
        DRAIN: begin
          if (i_ready) begin
            if (o_last) begin
              o_valid <= 1'b0;
              o_last  <= 1'b0;
              state   <= WAIT_CLR;
            end else begin
              row    <= next_row;
              col    <= next_col;
              o_last <= (next_row == n_q - 3'd1) && (next_col == n_q - 3'd1);
            end
          end
        end
        WAIT_CLR: begin
          if (!all_done) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
